// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : regfile_pkg
// Brief    : Shared types and helpers for the multi-port register file.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_t;

   localparam logic C_ZERO_BIT = 1'b0;

   function automatic int rf_depth(input int aw);
      return 1 << aw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_rdport.sv
//------------------------------------------------------------------------------
// Module   : regfile_rdport
// Brief    : One read port: write-to-read bypass and register-0 forcing.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int BYPASS     = 1
) (
   input  logic [ADDR_WIDTH-1:0] i_ra,
   input  logic [DATA_WIDTH-1:0] i_stored,
   input  logic                  i_we0,
   input  logic [ADDR_WIDTH-1:0] i_wa0,
   input  logic [DATA_WIDTH-1:0] i_wd0,
   input  logic                  i_we1,
   input  logic [ADDR_WIDTH-1:0] i_wa1,
   input  logic [DATA_WIDTH-1:0] i_wd1,
   output logic [DATA_WIDTH-1:0] o_data
);

   // Port 1 is checked last so it overrides port 0 on an address match.
   always_comb begin
      o_data = i_stored;
      if (BYPASS != 0) begin
         if (i_we0 && (i_wa0 == i_ra)) o_data = i_wd0;
         if (i_we1 && (i_wa1 == i_ra)) o_data = i_wd1;
      end
      if (i_ra == '0) o_data = {DATA_WIDTH{C_ZERO_BIT}};
   end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
//------------------------------------------------------------------------------
// Module   : regfile_mp
// Brief    : Multi-port register file, two prioritised write ports, registered
//            reads, r0 hard-wired to zero, sequential clear after reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we0,
   input  logic [ADDR_WIDTH-1:0]        wa0,
   input  logic [DATA_WIDTH-1:0]        wd0,
   input  logic                         we1,
   input  logic [ADDR_WIDTH-1:0]        wa1,
   input  logic [DATA_WIDTH-1:0]        wd1,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd,
   output logic                         ready
);

   localparam int DEPTH = rf_depth(ADDR_WIDTH);

   rf_state_t                    r_state;
   rf_state_t                    w_state_next;
   logic [ADDR_WIDTH-1:0]        r_clr_idx;
   logic                         r_ready;
   logic [NUM_RD*DATA_WIDTH-1:0] r_rd;
   logic [NUM_RD*DATA_WIDTH-1:0] w_rd;
   logic [DATA_WIDTH-1:0]        r_mem [DEPTH];
   logic                         w_wr0;
   logic                         w_wr1;

   assign w_wr0 = we0 && (wa0 != '0);
   assign w_wr1 = we1 && (wa1 != '0);

   always_ff @(posedge clk) begin
      if (rst) r_state <= CLEAR;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         CLEAR:   if (&r_clr_idx) w_state_next = READY;
         READY:   w_state_next = READY;
         default: w_state_next = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clr_idx <= '0;
         r_ready   <= 1'b0;
         r_rd      <= '0;
      end else begin
         if (r_state == CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
         r_ready <= (w_state_next == READY);
         r_rd    <= (r_state == READY) ? w_rd : '0;
      end
   end

   // Storage has no reset of its own; the clear sequencer zeroes it.
   // Port 1 is assigned last so it wins a same-address collision.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == CLEAR) begin
            r_mem[r_clr_idx] <= {DATA_WIDTH{C_ZERO_BIT}};
         end else begin
            if (w_wr0) r_mem[wa0] <= wd0;
            if (w_wr1) r_mem[wa1] <= wd1;
         end
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rdport
      regfile_rdport #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH),
         .BYPASS     (BYPASS)
      ) u_rdport (
         .i_ra     (ra[k*ADDR_WIDTH +: ADDR_WIDTH]),
         .i_stored (r_mem[ra[k*ADDR_WIDTH +: ADDR_WIDTH]]),
         .i_we0    (we0),
         .i_wa0    (wa0),
         .i_wd0    (wd0),
         .i_we1    (we1),
         .i_wa1    (wa1),
         .i_wd1    (wd1),
         .o_data   (w_rd[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign rd    = r_rd;
   assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
//------------------------------------------------------------------------------
// Module   : tb_regfile_mp
// Brief    : Scoreboard bench: default file (bypass on/off) and a 3-port
//            8x16 variant, sharing clock and reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we0, we1;
   logic [4:0]  wa0, wa1;
   logic [31:0] wd0, wd1;
   logic [9:0]  ra;
   logic [63:0] rd_a, rd_c;
   logic        ready_a, ready_c;

   logic        b_we0, b_we1;
   logic [2:0]  b_wa0, b_wa1;
   logic [15:0] b_wd0, b_wd1;
   logic [8:0]  b_ra;
   logic [47:0] b_rd;
   logic        ready_b;

   int checks   = 0;
   int failures = 0;
   int edges    = 0;

   int          q_stamp[$];
   int          q_dut[$];
   int          q_port[$];
   logic [31:0] q_exp[$];
   string       q_tag[$];

   always #5 clk = ~clk;
   always @(posedge clk) edges++;

   regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1)) u_dut_a (
      .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
      .wd1(wd1), .ra(ra), .rd(rd_a), .ready(ready_a));

   regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)) u_dut_c (
      .clk(clk), .rst(rst), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
      .wd1(wd1), .ra(ra), .rd(rd_c), .ready(ready_c));

   regfile_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(3), .BYPASS(1)) u_dut_b (
      .clk(clk), .rst(rst), .we0(b_we0), .wa0(b_wa0), .wd0(b_wd0), .we1(b_we1),
      .wa1(b_wa1), .wd1(b_wd1), .ra(b_ra), .rd(b_rd), .ready(ready_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Expected read data lands after the next rising edge.
   task automatic expect_rd(input int dut, input int port, input logic [31:0] exp,
                            input string tag);
      q_stamp.push_back(edges + 1);
      q_dut.push_back(dut);
      q_port.push_back(port);
      q_exp.push_back(exp);
      q_tag.push_back(tag);
   endtask

   task automatic expect_ac(input int port, input logic [31:0] ea, input logic [31:0] ec,
                            input string tag);
      expect_rd(0, port, ea, {tag, "_byp1"});
      expect_rd(1, port, ec, {tag, "_byp0"});
   endtask

   task automatic idle_ac();
      we0 = 1'b0; wa0 = '0; wd0 = '0;
      we1 = 1'b0; wa1 = '0; wd1 = '0;
      ra  = '0;
   endtask

   task automatic idle_b();
      b_we0 = 1'b0; b_wa0 = '0; b_wd0 = '0;
      b_we1 = 1'b0; b_wa1 = '0; b_wd1 = '0;
      b_ra  = '0;
   endtask

   always @(negedge clk) begin
      while (q_stamp.size() > 0 && q_stamp[0] <= edges) begin
         int          d, p;
         logic [31:0] e, act;
         string       t;
         void'(q_stamp.pop_front());
         d = q_dut.pop_front();
         p = q_port.pop_front();
         e = q_exp.pop_front();
         t = q_tag.pop_front();
         case (d)
            0:       act = rd_a[p*32 +: 32];
            1:       act = rd_c[p*32 +: 32];
            default: act = {16'h0, b_rd[p*16 +: 16]};
         endcase
         check(t, act, e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int n, nb;
      idle_ac();
      idle_b();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", {31'h0, ready_a}, 32'h0);
      check("rst_rd_lo", rd_a[31:0], 32'h0);
      check("rst_rd_hi", rd_a[63:32], 32'h0);
      check("rst_rd_b", b_rd[31:0], 32'h0);
      rst = 1'b0;

      n = 0; nb = 0;
      while (!ready_a && n < 100) begin
         @(negedge clk);
         n++;
         if (ready_b && nb == 0) nb = n;
      end
      check("clear_len", n, 32);
      check("clear_len_b", nb, 8);
      check("ready_c", {31'h0, ready_c}, 32'h1);

      for (int a = 0; a < 32; a += 2) begin
         ra = {5'(a + 1), 5'(a)};
         expect_ac(0, 32'h0, 32'h0, "clr_rd0");
         expect_ac(1, 32'h0, 32'h0, "clr_rd1");
         @(negedge clk);
      end

      idle_ac();
      we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
      @(negedge clk);
      idle_ac();
      ra = {5'd5, 5'd5};
      expect_ac(0, 32'hDEADBEEF, 32'hDEADBEEF, "r5_p0");
      expect_ac(1, 32'hDEADBEEF, 32'hDEADBEEF, "r5_p1");
      @(negedge clk);

      idle_ac();
      we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11111111;
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22222222;
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
      we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
      ra = {5'd7, 5'd0};
      expect_ac(0, 32'h0, 32'h0, "r0_during_wr");
      expect_ac(1, 32'h22222222, 32'h22222222, "r7_conflict");
      @(negedge clk);
      idle_ac();
      ra = {5'd0, 5'd0};
      expect_ac(0, 32'h0, 32'h0, "r0_after_wr");
      @(negedge clk);

      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h00000001;
      ra = '0;
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hA5A5A5A5;
      ra = {5'd9, 5'd9};
      expect_ac(0, 32'hA5A5A5A5, 32'h00000001, "r9_bypass_p0");
      expect_ac(1, 32'hA5A5A5A5, 32'h00000001, "r9_bypass_p1");
      @(negedge clk);
      we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h00000003;
      we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h00000004;
      ra = {5'd10, 5'd9};
      expect_ac(0, 32'hA5A5A5A5, 32'hA5A5A5A5, "r9_stored");
      expect_ac(1, 32'h00000004, 32'h00000000, "r10_bypass_prio");
      @(negedge clk);
      idle_ac();
      ra = {5'd10, 5'd10};
      expect_ac(0, 32'h00000004, 32'h00000004, "r10_stored");
      @(negedge clk);
      idle_ac();

      b_we0 = 1'b1; b_wa0 = 3'd1; b_wd0 = 16'h1111;
      b_we1 = 1'b1; b_wa1 = 3'd2; b_wd1 = 16'h2222;
      @(negedge clk);
      b_we0 = 1'b1; b_wa0 = 3'd3; b_wd0 = 16'hBEEF;
      b_we1 = 1'b0;
      @(negedge clk);
      idle_b();
      b_ra = {3'd2, 3'd1, 3'd3};
      expect_rd(2, 0, 32'h0000BEEF, "b_p0_r3");
      expect_rd(2, 1, 32'h00001111, "b_p1_r1");
      expect_rd(2, 2, 32'h00002222, "b_p2_r2");
      @(negedge clk);
      idle_b();

      // Restart the clear part-way through, then attempt writes behind the sweep.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n = 0; nb = 0;
      while (!ready_a && n < 100) begin
         @(negedge clk);
         n++;
         if (ready_b && nb == 0) nb = n;
         if (n == 12) begin
            we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h12345678;
            we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h87654321;
            ra  = {5'd7, 5'd5};
            expect_ac(0, 32'h0, 32'h0, "rd_during_clear");
         end
         if (n == 20) idle_ac();
      end
      check("restart_len", n, 32);
      check("restart_len_b", nb, 8);
      idle_ac();
      ra = {5'd7, 5'd5};
      expect_ac(0, 32'h0, 32'h0, "r5_after_clear");
      expect_ac(1, 32'h0, 32'h0, "r7_after_clear");
      b_ra = {3'd0, 3'd0, 3'd3};
      expect_rd(2, 0, 32'h0, "b_r3_after_clear");
      @(negedge clk);
      idle_ac();
      idle_b();
      repeat (3) @(negedge clk);

      check("scoreboard_drained", q_stamp.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the MIPS datapath: configurable read-port count, two write ports with fixed priority, and optional write-to-read bypass. Register 0 is hard-wired to zero. On reset, a clear sequencer zeroes every entry one per cycle and then asserts `ready`. Reads are registered with 1-cycle latency, so it replaces the single-write/two-read file in the decode stage.

## Interface

- `DATA_WIDTH`, 32, bits per register
- `ADDR_WIDTH`, 5, address bits; DEPTH = 2**ADDR_WIDTH
- `NUM_RD`, 2, number of read ports (1..4)
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads; 0 = read-before-write

Ports:

- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `we0` in 1: write enable, port 0
- `wa0` in ADDR_WIDTH: write address, port 0
- `wd0` in DATA_WIDTH: write data, port 0
- `we1` in 1: write enable, port 1 (higher priority)
- `wa1` in ADDR_WIDTH: write address, port 1
- `wd1` in DATA_WIDTH: write data, port 1
- `ra` in NUM_RD*ADDR_WIDTH: packed read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- `rd` out NUM_RD*DATA_WIDTH: packed registered read data, same packing
- `ready` out 1: clear finished, file usable

## Operation

- FSM states CLEAR and READY.
  - `rst`=1 forces CLEAR, `clr_idx`=0, `ready`=0, `rd`=0. This applies in any state, including mid-clear, which restarts the clear from index 0.
  - In CLEAR with `rst`=0: write 0 to `register[clr_idx]`, then increment. When `clr_idx`==DEPTH-1 is written, go to READY.
  - READY holds until `rst`.
- During CLEAR: `we0`/`we1` are ignored; `rd` outputs all 0.
- In READY, writes:
  - A write occurs when `weN`=1 and `waN`!=0; writes to address 0 are dropped.
  - Both ports to the same address in one cycle: port 1 data stored.
- In READY, reads, per port k:
  - `ra_k`==0 gives 0.
  - Else if BYPASS=1 and a qualifying write to `ra_k` occurs this cycle, that write's data (port 1 over port 0).
  - Else the stored value before this edge.
  - With BYPASS=0 a simultaneous write returns the old value.
- Data is never truncated or extended; all paths are DATA_WIDTH wide.

## Timing

- Read latency is 1 cycle: `ra` sampled at edge N appears on `rd` after edge N. `rd` holds between edges.
- Write visible to a non-bypassed read issued at the next edge (N+1).
- `rst` deasserted before edge 0: edges 0..DEPTH-1 clear entries 0..DEPTH-1; `ready`=1 after edge DEPTH-1 (DEPTH cycles total).
- `ready` is registered; the first usable write/read edge is the one after `ready` rises.
- Reset values: `rd`=0, `ready`=0, `clr_idx`=0, state CLEAR.

## Structure

- Package `regfile_pkg`:
  - `rf_state_t` enum {CLEAR, READY}
  - localparam helper for DEPTH
  - zero constant
- Sub-module `regfile_rdport`: per-port address compare, bypass mux and zero-address forcing, generated NUM_RD times. Its output register lives in the parent.
- Storage is a plain array; no memory macro is required.

## Test plan

- Clear: assert `rst` 2 cycles, release.
  - `ready`=0 for 32 cycles, rises after edge 31.
  - Reading all 32 addresses then returns 0.
- Write/read: write 0xDEADBEEF to r5 via port 0, next cycle read r5 on both ports → 0xDEADBEEF after 1 edge.
- Conflict: `we0`/`we1` both to r7 with 0x11111111/0x22222222 → later read of r7 = 0x22222222. Write 0xFFFFFFFF to r0 → read r0 = 0.
- Bypass: write r9=0xA5A5A5A5 while reading r9 (previously 0x1).
  - BYPASS=1 gives 0xA5A5A5A5 after the edge.
  - BYPASS=0 gives 0x00000001.
- Reset mid-clear: pulse `rst` at clear cycle 10 → `ready` rises exactly 32 cycles after release. Writes attempted during clear leave their targets 0.
- Parameter sweep NUM_RD=3, ADDR_WIDTH=3, DATA_WIDTH=16: `ready` after 8 cycles; three independent reads of distinct written values are correct.
